// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg: shared constants for the DSP16 serial I/O port
// (register selects, sioc bit indexes, bit-clock divider table).
package jtdsp16_pkg;

   localparam logic [1:0] SEL_SDX  = 2'b00;
   localparam logic [1:0] SEL_SIOC = 2'b01;
   localparam logic [1:0] SEL_SRTA = 2'b10;
   localparam logic [1:0] SEL_RSV  = 2'b11;

   localparam int SIOC_DIV  = 0;
   localparam int SIOC_MSB  = 2;
   localparam int SIOC_LEN8 = 3;
   localparam int SIOC_LOOP = 4;
   localparam int SIOC_IEN  = 5;
   localparam int SIOC_OVR  = 6;

   // half sck period minus one, in cen ticks
   localparam logic [3:0] HALF_M1_4  = 4'd1;
   localparam logic [3:0] HALF_M1_8  = 4'd3;
   localparam logic [3:0] HALF_M1_16 = 4'd7;
   localparam logic [3:0] HALF_M1_32 = 4'd15;

   localparam logic [3:0] LAST_8  = 4'd7;
   localparam logic [3:0] LAST_16 = 4'd15;

   typedef enum logic {
      SH_IDLE,
      SH_RUN
   } sh_st_t;

   function automatic logic [3:0] half_m1(input logic [1:0] div);
      logic [3:0] h;
      unique case (div)
         2'd0: h = HALF_M1_4;
         2'd1: h = HALF_M1_8;
         2'd2: h = HALF_M1_16;
         2'd3: h = HALF_M1_32;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/jtdsp16_sio_shift.sv
// jtdsp16_sio_shift: 16/8-bit serial shifter, MSB- or LSB-first.
// Mode is captured on load so a word keeps its format to the end.
module jtdsp16_sio_shift
   import jtdsp16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ld,
   input  logic [15:0] ld_data,
   input  logic        msb,
   input  logic        len8,
   input  logic        shift,
   input  logic        sin,
   output logic        sout,
   output logic [15:0] data,
   output logic        last
);

   logic [15:0] sh;
   logic [3:0]  cnt;
   logic        msb_q;
   logic        len8_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh     <= '0;
         cnt    <= '0;
         msb_q  <= 1'b0;
         len8_q <= 1'b0;
      end else if (ld) begin
         sh     <= ld_data;
         cnt    <= '0;
         msb_q  <= msb;
         len8_q <= len8;
      end else if (shift) begin
         sh  <= msb_q ? {sh[14:0], sin}
                      : {sin, sh[15:1]};
         cnt <= cnt + 4'd1;
      end
   end

   assign last = cnt == (len8_q ? LAST_8 : LAST_16);

   assign sout = msb_q ? (len8_q ? sh[7] : sh[15])
                       : sh[0];

   // 8-bit words land low in MSB mode, high in LSB mode
   always_comb begin
      data = sh;
      if (len8_q)
         data = msb_q ? {8'h00, sh[7:0]}
                      : {8'h00, sh[15:8]};
   end

endmodule

// File: rtl/jtdsp16_sio.sv
// jtdsp16_sio: DSP16 serial I/O port with sdx/sioc/srta registers.
// Define JTDSP16_SIO_LOOP_EN to enable sioc[4] output-to-input loopback.
module jtdsp16_sio
   import jtdsp16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        sio_wr,
   input  logic        sio_rd,
   input  logic [1:0]  reg_sel,
   input  logic [15:0] din,
   output logic [15:0] r_sio,
   input  logic        di,
   output logic        do_o,
   output logic        sck,
   output logic        ild,
   output logic        old,
   output logic        ibf,
   output logic        obe
);

`ifdef JTDSP16_SIO_LOOP_EN
   localparam logic [5:0] SIOC_WMASK = 6'h3F;
`else
   localparam logic [5:0] SIOC_WMASK = 6'h2F;
`endif

   logic [5:0]  sioc;
   logic        ovr;
   logic [15:0] srta;
   logic [15:0] obuf;
   logic [15:0] ibuf;
   logic [3:0]  dcnt;
   logic [1:0]  div_q;
   logic        sck_q;
   logic        tick;
   logic        rise;
   logic        fall;
   logic        wr_sdx;
   logic        wr_sioc;
   logic        wr_srta;
   logic        rd_sdx;
   sh_st_t      o_st;
   sh_st_t      o_nx;
   sh_st_t      i_st;
   sh_st_t      i_nx;
   logic        o_ld;
   logic        o_sh;
   logic        o_last;
   logic        o_sout;
   logic [15:0] o_data;
   logic        i_ld;
   logic        i_sh;
   logic        i_last;
   logic        i_sout;
   logic [15:0] i_data;
   logic        i_done;
   logic        i_cpy;
   logic        i_sin;
   logic        unused_sh;

   assign wr_sdx  = sio_wr && reg_sel == SEL_SDX;
   assign wr_sioc = sio_wr && reg_sel == SEL_SIOC;
   assign wr_srta = sio_wr && reg_sel == SEL_SRTA;
   assign rd_sdx  = sio_rd && reg_sel == SEL_SDX;

   assign tick = cen && dcnt == half_m1(div_q);
   assign rise = tick && !sck_q;
   assign fall = tick && sck_q;
   assign sck  = sck_q;

   // divider setting only switches on a bit boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt  <= '0;
         sck_q <= 1'b0;
         div_q <= '0;
      end else if (cen) begin
         if (tick) begin
            dcnt  <= '0;
            sck_q <= ~sck_q;
            if (!sck_q)
               div_q <= sioc[SIOC_DIV +: 2];
         end else begin
            dcnt <= dcnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_st <= SH_IDLE;
         i_st <= SH_IDLE;
      end else begin
         o_st <= o_nx;
         i_st <= i_nx;
      end
   end

   always_comb begin
      o_nx = o_st;
      o_ld = 1'b0;
      o_sh = 1'b0;
      if (rise) begin
         if (o_st == SH_RUN && !o_last) begin
            o_sh = 1'b1;
         end else if (!obe) begin
            o_ld = 1'b1;
            o_nx = SH_RUN;
         end else begin
            o_nx = SH_IDLE;
         end
      end
   end

   always_comb begin
      i_nx   = i_st;
      i_ld   = 1'b0;
      i_sh   = 1'b0;
      i_done = 1'b0;
      if (rise && i_st == SH_IDLE && sioc[SIOC_IEN]) begin
         i_ld = 1'b1;
         i_nx = SH_RUN;
      end
      if (fall && i_st == SH_RUN) begin
         i_sh = 1'b1;
         if (i_last) begin
            i_done = 1'b1;
            i_nx   = SH_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sioc  <= '0;
         ovr   <= 1'b0;
         srta  <= '0;
         obuf  <= '0;
         obe   <= 1'b1;
         ibuf  <= '0;
         ibf   <= 1'b0;
         old   <= 1'b0;
         ild   <= 1'b0;
         i_cpy <= 1'b0;
      end else begin
         i_cpy <= i_done;
         if (wr_sioc)
            sioc <= din[5:0] & SIOC_WMASK;
         if (wr_srta)
            srta <= din;
         if (wr_sdx)
            obuf <= din;
         if (wr_sdx)
            obe <= 1'b0;
         else if (o_ld)
            obe <= 1'b1;
         if (rise) begin
            old <= o_ld;
            ild <= i_ld;
         end
         // a completing word beats a same-cycle read clear
         if (i_cpy)
            ibuf <= i_data;
         if (i_cpy)
            ibf <= 1'b1;
         else if (rd_sdx)
            ibf <= 1'b0;
         if (i_cpy && ibf)
            ovr <= 1'b1;
         else if (wr_sioc)
            ovr <= 1'b0;
      end
   end

`ifdef JTDSP16_SIO_LOOP_EN
   logic loop_q;

   always_ff @(posedge clk) begin
      if (rst)
         loop_q <= 1'b0;
      else if (i_ld)
         loop_q <= sioc[SIOC_LOOP];
   end

   assign i_sin = loop_q ? do_o : di;
`else
   assign i_sin = di;
`endif

   jtdsp16_sio_shift u_out (
      .clk     (clk),
      .rst     (rst),
      .ld      (o_ld),
      .ld_data (obuf),
      .msb     (sioc[SIOC_MSB]),
      .len8    (sioc[SIOC_LEN8]),
      .shift   (o_sh),
      .sin     (1'b0),
      .sout    (o_sout),
      .data    (o_data),
      .last    (o_last)
   );

   jtdsp16_sio_shift u_in (
      .clk     (clk),
      .rst     (rst),
      .ld      (i_ld),
      .ld_data (16'h0000),
      .msb     (sioc[SIOC_MSB]),
      .len8    (sioc[SIOC_LEN8]),
      .shift   (i_sh),
      .sin     (i_sin),
      .sout    (i_sout),
      .data    (i_data),
      .last    (i_last)
   );

   assign unused_sh = ^{o_data, i_sout};

   assign do_o = o_st == SH_RUN && o_sout;

   always_comb begin
      r_sio = '0;
      unique case (reg_sel)
         SEL_SDX:  r_sio = ibuf;
         SEL_SIOC: r_sio = {9'd0, ovr, sioc};
         SEL_SRTA: r_sio = srta;
         SEL_RSV:  r_sio = '0;
      endcase
   end

endmodule
